// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction fetch stage with the FD pipeline register folded in. Owns the
// program counter, runs a request/ready handshake against instruction memory
// and hands the fetched instruction, its PC and pre-split register fields to
// decode and the hazard unit. A one-entry skid buffer catches a response that
// lands in the same cycle as a stall, so it is never lost.
//
// Ports
//   clk            in   clock, all state updates on the rising edge
//   rst_n          in   asynchronous active-low reset
//   stall_F        in   hold FD register and PC
//   flush_F        in   invalidate FD register and skid buffer
//   branch_taken   in   redirect request, target on branch_target
//   branch_target  in   [PC_W-1:0] redirect address
//   imem_req       out  fetch request (decoded from state only)
//   imem_addr      out  [PC_W-1:0] fetch address, stable while waiting
//   imem_ready     in   response valid this cycle
//   imem_rdata     in   [INSTR_W-1:0] instruction
//   instr_D        out  [INSTR_W-1:0] FD-register instruction
//   pc_D           out  [PC_W-1:0] PC of instr_D
//   valid_D        out  instr_D is a real instruction
//   opcode_D       out  [4:0] instr_D[15:11], 0 when invalid
//   rd_D           out  [2:0] instr_D[10:8], 0 when invalid
//   source_reg1_D  out  [2:0] instr_D[7:5], 0 when invalid
//   source_reg2_D  out  [2:0] instr_D[4:2], 0 when invalid
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter int              PC_W     = 8,
    parameter int              INSTR_W  = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall_F,
    input  logic               flush_F,
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    branch_target,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ready,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr_D,
    output logic [PC_W-1:0]    pc_D,
    output logic               valid_D,
    output logic [4:0]         opcode_D,
    output logic [2:0]         rd_D,
    output logic [2:0]         source_reg1_D,
    output logic [2:0]         source_reg2_D
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    // Registers
    state_t               r_state;
    logic                 r_run;          // low until the first edge after reset
    logic [PC_W-1:0]      r_fetch_addr;
    logic [PC_W-1:0]      r_pc_next;
    logic [INSTR_W-1:0]   r_skid_instr;
    logic [PC_W-1:0]      r_skid_pc;
    logic [INSTR_W-1:0]   r_instr_d;
    logic [PC_W-1:0]      r_pc_d;
    logic                 r_valid_d;

    // Next-state values
    state_t               w_state_next;
    logic                 w_run_next;
    logic [PC_W-1:0]      w_fetch_addr_next;
    logic [PC_W-1:0]      w_pc_next_next;
    logic [INSTR_W-1:0]   w_skid_instr_next;
    logic [PC_W-1:0]      w_skid_pc_next;
    logic [INSTR_W-1:0]   w_instr_d_next;
    logic [PC_W-1:0]      w_pc_d_next;
    logic                 w_valid_d_next;

    logic [PC_W-1:0]      w_fetch_addr_inc;
    logic [PC_W-1:0]      w_skid_pc_inc;

    assign w_fetch_addr_inc = r_fetch_addr + PC_W'(1);
    assign w_skid_pc_inc    = r_skid_pc + PC_W'(1);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_FETCH;
            r_run        <= 1'b0;
            r_fetch_addr <= RESET_PC;
            r_pc_next    <= RESET_PC;
            r_skid_instr <= '0;
            r_skid_pc    <= '0;
            r_instr_d    <= '0;
            r_pc_d       <= '0;
            r_valid_d    <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_run        <= w_run_next;
            r_fetch_addr <= w_fetch_addr_next;
            r_pc_next    <= w_pc_next_next;
            r_skid_instr <= w_skid_instr_next;
            r_skid_pc    <= w_skid_pc_next;
            r_instr_d    <= w_instr_d_next;
            r_pc_d       <= w_pc_d_next;
            r_valid_d    <= w_valid_d_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next      = r_state;
        w_run_next        = 1'b1;
        w_fetch_addr_next = r_fetch_addr;
        w_pc_next_next    = r_pc_next;
        w_skid_instr_next = r_skid_instr;
        w_skid_pc_next    = r_skid_pc;
        w_instr_d_next    = r_instr_d;
        w_pc_d_next       = r_pc_d;
        w_valid_d_next    = r_valid_d;

        case (r_state)
            S_FETCH: begin
                // No request is outstanding before r_run rises.
                if (r_run) begin
                    if (branch_taken) begin
                        w_pc_next_next = branch_target;
                        if (imem_ready) begin
                            // Response in this cycle is wrong-path; drop it.
                            w_fetch_addr_next = branch_target;
                        end else begin
                            // Request already on the bus must finish first.
                            w_state_next = S_DRAIN;
                        end
                    end else if (imem_ready) begin
                        if (flush_F) begin
                            // Flushed response is dropped; fetch continues.
                            w_fetch_addr_next = w_fetch_addr_inc;
                        end else if (stall_F) begin
                            w_skid_instr_next = imem_rdata;
                            w_skid_pc_next    = r_fetch_addr;
                            w_state_next      = S_HOLD;
                        end else begin
                            w_instr_d_next    = imem_rdata;
                            w_pc_d_next       = r_fetch_addr;
                            w_valid_d_next    = 1'b1;
                            w_fetch_addr_next = w_fetch_addr_inc;
                        end
                    end
                end
            end

            S_HOLD: begin
                if (branch_taken) begin
                    // Skid content is younger than the branch: discard it.
                    w_pc_next_next    = branch_target;
                    w_fetch_addr_next = branch_target;
                    w_skid_instr_next = '0;
                    w_skid_pc_next    = '0;
                    w_state_next      = S_FETCH;
                end else if (flush_F) begin
                    w_fetch_addr_next = w_skid_pc_inc;
                    w_state_next      = S_FETCH;
                end else if (!stall_F) begin
                    w_instr_d_next    = r_skid_instr;
                    w_pc_d_next       = r_skid_pc;
                    w_valid_d_next    = 1'b1;
                    w_fetch_addr_next = w_skid_pc_inc;
                    w_state_next      = S_FETCH;
                end
            end

            S_DRAIN: begin
                // Last target seen wins, including one arriving with ready.
                if (branch_taken) begin
                    w_pc_next_next = branch_target;
                end
                if (imem_ready) begin
                    w_fetch_addr_next = branch_taken ? branch_target : r_pc_next;
                    w_state_next      = S_FETCH;
                end
            end

            default: begin
                w_state_next = S_FETCH;
            end
        endcase

        // Outside DRAIN, pc_next simply tracks the address about to be fetched.
        if (r_state != S_DRAIN && !branch_taken) begin
            w_pc_next_next = w_fetch_addr_next;
        end

        // Flush beats stall and any FD load chosen above.
        if (flush_F) begin
            w_instr_d_next    = '0;
            w_valid_d_next    = 1'b0;
            w_skid_instr_next = '0;
            w_skid_pc_next    = '0;
        end
    end

    // Outputs: registered values or state decode only
    assign imem_req      = r_run && (r_state != S_HOLD);
    assign imem_addr     = r_fetch_addr;
    assign instr_D       = r_instr_d;
    assign pc_D          = r_pc_d;
    assign valid_D       = r_valid_d;
    assign opcode_D      = r_valid_d ? r_instr_d[15:11] : 5'd0;
    assign rd_D          = r_valid_d ? r_instr_d[10:8]  : 3'd0;
    assign source_reg1_D = r_valid_d ? r_instr_d[7:5]   : 3'd0;
    assign source_reg2_D = r_valid_d ? r_instr_d[4:2]   : 3'd0;

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//
// Directed bench for fetch_stage. Instruction memory returns addr + 0x100.
// Stimulus pushes the expected handshake addresses and FD-register contents
// into queues; a monitor on the falling edge pops and compares whenever the
// DUT completes a memory handshake or presents a new FD entry.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

    localparam int PC_W    = 8;
    localparam int INSTR_W = 16;

    logic               clk;
    logic               rst_n;
    logic               stall_F;
    logic               flush_F;
    logic               branch_taken;
    logic [PC_W-1:0]    branch_target;
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_ready;
    logic [INSTR_W-1:0] imem_rdata;
    logic [INSTR_W-1:0] instr_D;
    logic [PC_W-1:0]    pc_D;
    logic               valid_D;
    logic [4:0]         opcode_D;
    logic [2:0]         rd_D;
    logic [2:0]         source_reg1_D;
    logic [2:0]         source_reg2_D;

    typedef struct {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fd_t;

    logic [PC_W-1:0] addr_q[$];
    fd_t             fd_q[$];

    int n_pass  = 0;
    int n_total = 0;

    fetch_stage #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W),
        .RESET_PC(8'h00)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_F       (stall_F),
        .flush_F       (flush_F),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .instr_D       (instr_D),
        .pc_D          (pc_D),
        .valid_D       (valid_D),
        .opcode_D      (opcode_D),
        .rd_D          (rd_D),
        .source_reg1_D (source_reg1_D),
        .source_reg2_D (source_reg2_D)
    );

    // memory[i] = i + 0x100
    assign imem_rdata = 16'h0100 + {8'h00, imem_addr};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_addr(input logic [PC_W-1:0] a);
        addr_q.push_back(a);
    endtask

    task automatic push_fd(input logic [PC_W-1:0] a);
        fd_t e;
        e.pc    = a;
        e.instr = 16'h0100 + {8'h00, a};
        fd_q.push_back(e);
    endtask

    // Monitor / scoreboard
    initial begin
        logic            prev_valid;
        logic [PC_W-1:0] prev_pc;
        logic [PC_W-1:0] ea;
        fd_t             ef;
        prev_valid = 1'b0;
        prev_pc    = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (imem_req && imem_ready) begin
                    if (addr_q.size() == 0) begin
                        check("unexpected_req", {24'h0, imem_addr}, 32'hFFFF_FFFF);
                    end else begin
                        ea = addr_q.pop_front();
                        check("req_addr", {24'h0, imem_addr}, {24'h0, ea});
                        $display("req   addr=0x%02h exp=0x%02h", imem_addr, ea);
                    end
                end
                if (valid_D && (!prev_valid || pc_D != prev_pc)) begin
                    if (fd_q.size() == 0) begin
                        check("unexpected_fd", {24'h0, pc_D}, 32'hFFFF_FFFF);
                    end else begin
                        ef = fd_q.pop_front();
                        check("fd_pc",    {24'h0, pc_D},          {24'h0, ef.pc});
                        check("fd_instr", {16'h0, instr_D},       {16'h0, ef.instr});
                        check("fd_op",    {27'h0, opcode_D},      {27'h0, ef.instr[15:11]});
                        check("fd_rd",    {29'h0, rd_D},          {29'h0, ef.instr[10:8]});
                        check("fd_rs1",   {29'h0, source_reg1_D}, {29'h0, ef.instr[7:5]});
                        check("fd_rs2",   {29'h0, source_reg2_D}, {29'h0, ef.instr[4:2]});
                        $display("fd    pc=0x%02h instr=0x%04h exp pc=0x%02h instr=0x%04h",
                                 pc_D, instr_D, ef.pc, ef.instr);
                    end
                end
            end
            prev_valid = valid_D;
            prev_pc    = pc_D;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    // Stimulus
    initial begin
        rst_n         = 1'b1;
        stall_F       = 1'b0;
        flush_F       = 1'b0;
        branch_taken  = 1'b0;
        branch_target = '0;
        imem_ready    = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req",   {31'h0, imem_req}, 32'h0);
        check("rst_valid", {31'h0, valid_D},  32'h0);
        check("rst_instr", {16'h0, instr_D},  32'h0);
        check("rst_pc",    {24'h0, pc_D},     32'h0);

        // Back-to-back fetch from reset
        push_addr(8'h00); push_addr(8'h01); push_addr(8'h02); push_addr(8'h03);
        push_fd(8'h00);   push_fd(8'h01);   push_fd(8'h02);
        rst_n = 1'b1;
        tick();
        check("first_req",  {31'h0, imem_req},  32'h1);
        check("first_addr", {24'h0, imem_addr}, 32'h0);
        tick();
        check("first_valid", {31'h0, valid_D}, 32'h1);
        tick();
        tick();

        // Stall with the response for address 3, held 3 cycles
        stall_F = 1'b1;
        tick();
        check("hold_req0", {31'h0, imem_req}, 32'h0);
        tick();
        check("hold_req1", {31'h0, imem_req}, 32'h0);
        tick();
        check("hold_req2",  {31'h0, imem_req}, 32'h0);
        check("hold_fd_pc", {24'h0, pc_D},     32'h2);
        stall_F = 1'b0;
        push_fd(8'h03);
        tick();
        check("unstall_addr", {24'h0, imem_addr}, 32'h4);

        // Delayed ready with a branch in the first waiting cycle
        imem_ready    = 1'b0;
        branch_taken  = 1'b1;
        branch_target = 8'h40;
        tick();
        branch_taken = 1'b0;
        check("drain_addr0", {24'h0, imem_addr}, 32'h4);
        check("drain_req0",  {31'h0, imem_req},  32'h1);
        tick();
        check("drain_addr1", {24'h0, imem_addr}, 32'h4);
        imem_ready = 1'b1;
        push_addr(8'h04); push_addr(8'h40); push_addr(8'h41);
        push_fd(8'h40);
        tick();
        check("redirect_addr", {24'h0, imem_addr}, 32'h40);
        tick();

        // Into HOLD, then flush + stall + branch together
        stall_F = 1'b1;
        tick();
        flush_F       = 1'b1;
        branch_taken  = 1'b1;
        branch_target = 8'h80;
        tick();
        flush_F      = 1'b0;
        branch_taken = 1'b0;
        stall_F      = 1'b0;
        check("flush_valid", {31'h0, valid_D},       32'h0);
        check("flush_instr", {16'h0, instr_D},       32'h0);
        check("flush_op",    {27'h0, opcode_D},      32'h0);
        check("flush_rd",    {29'h0, rd_D},          32'h0);
        check("flush_rs1",   {29'h0, source_reg1_D}, 32'h0);
        check("flush_rs2",   {29'h0, source_reg2_D}, 32'h0);
        check("flush_addr",  {24'h0, imem_addr},     32'h80);
        push_addr(8'h80); push_addr(8'h81);
        push_fd(8'h80);
        tick();

        // Branch with ready high, then PC wrap 0xFF -> 0x00
        branch_taken  = 1'b1;
        branch_target = 8'hFE;
        tick();
        branch_taken = 1'b0;
        check("br_fd_untouched", {24'h0, pc_D}, 32'h80);
        push_addr(8'hFE); push_addr(8'hFF); push_addr(8'h00);
        push_fd(8'hFE);   push_fd(8'hFF);   push_fd(8'h00);
        tick();
        tick();
        tick();
        check("wrap_addr", {24'h0, imem_addr}, 32'h01);

        // Reset pulse while in DRAIN
        imem_ready    = 1'b0;
        branch_taken  = 1'b1;
        branch_target = 8'h20;
        tick();
        branch_taken = 1'b0;
        check("pre_rst_addr", {24'h0, imem_addr}, 32'h01);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_req",   {31'h0, imem_req}, 32'h0);
        check("async_rst_valid", {31'h0, valid_D},  32'h0);
        check("async_rst_instr", {16'h0, instr_D},  32'h0);
        check("async_rst_pc",    {24'h0, pc_D},     32'h0);
        tick();
        imem_ready = 1'b1;
        push_addr(8'h00); push_addr(8'h01);
        push_fd(8'h00);   push_fd(8'h01);
        rst_n = 1'b1;
        tick();
        check("post_rst_addr", {24'h0, imem_addr}, 32'h0);
        tick();
        tick();
        imem_ready = 1'b0;
        @(negedge clk);
        #1;
        check("addr_q_empty", addr_q.size(), 32'h0);
        check("fd_q_empty",   fd_q.size(),   32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
